// File: rtl/sipo_deser.sv
// sipo_deser: serial-in, parallel-out deserialiser feeding a small output FIFO.
// Bits are captured on load && sample_en, assembled into WIDTH-bit words, and
// each completed word is pushed into a DEPTH-entry FIFO with a valid/ready pop side.
// Optional feature macro: SIPO_FRAME_ERR_EN adds the frame_err output, which
// pulses when a frame ends on a partially assembled word.
module sipo_deser #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int LSB_FIRST = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load,
    input  logic                       sdi,
    input  logic                       sample_en,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
    output logic                       overflow
`ifdef SIPO_FRAME_ERR_EN
    ,
    output logic                       frame_err
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [OW-1:0] FULL_OCC = OW'(DEPTH);

    // Word assembly state
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shifted;
    logic             capture;
    logic             word_done;

    // FIFO state
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]    occ_q, occ_d;
    logic             overflow_q, overflow_d;
    logic             fifo_full;
    logic             pop;
    logic             push_ok;

    // Shift direction decides where the first received bit ends up once the word is complete
    generate
        if (LSB_FIRST != 0) begin : g_lsb_first
            assign shifted = {sdi, shift_q[WIDTH-1:1]};
        end else begin : g_msb_first
            assign shifted = {shift_q[WIDTH-2:0], sdi};
        end
    endgenerate

    assign capture   = load & sample_en;
    assign word_done = capture && (cnt_q == LAST_CNT);

    // Next-state for the assembly register and bit counter
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (!load) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (capture) begin
            if (word_done) begin
                // The full word leaves via the FIFO write port this edge
                shift_d = '0;
                cnt_d   = '0;
            end else begin
                shift_d = shifted;
                cnt_d   = cnt_q + CW'(1);
            end
        end
    end

    // Assembly register and bit counter
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid = (occ_q != '0);
    assign fifo_full = (occ_q == FULL_OCC);
    assign pop       = out_valid && out_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the push
    assign push_ok   = word_done && (!fifo_full || pop);

    // FIFO pointer, occupancy and sticky overflow next-state
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        overflow_d = overflow_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_ok, pop})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase
        if (word_done && fifo_full && !pop) begin
            overflow_d = 1'b1;
        end
    end

    // FIFO control registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            overflow_q <= overflow_d;
        end
    end

    // FIFO storage write; contents need no reset because the output is gated by out_valid
    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            mem[wr_ptr_q] <= shifted;
        end
    end

    assign out_data = out_valid ? mem[rd_ptr_q] : '0;
    assign bit_cnt  = cnt_q;
    assign overflow = overflow_q;

`ifdef SIPO_FRAME_ERR_EN
    logic frame_err_q;

    // A non-zero count implies load was high last cycle, so load low now ends a partial frame
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= !load && (cnt_q != '0);
        end
    end

    assign frame_err = frame_err_q;
`endif

endmodule
